attn_row_scheduler: RTL and testbench

Sequencing controller for the attention MAC/exp datapath. It accepts one query vector and `N_KEYS` key vectors per row from an upstream byte stream, and feeds operand pairs (q[f], k[f]) into the MAC engine's two-beat operand port. It clears the accumulator per key, captures the engine's combinational e^x result after each dot product, and accumulates the row sum. It then streams the `N_KEYS` exp values followed by their sum to the normalizer downstream.

---
 rtl/attn_row_scheduler.sv | 155 +++++++++++++++
 tb/tb_attn_row_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attn_row_scheduler.sv
// Row sequencer for the attention MAC/exp datapath: loads a query, pairs it with each key
// through the two-beat MAC operand port, captures e^x per key and streams exps plus their sum.
module attn_row_scheduler #(
  parameter int N_FEAT = 4,
  parameter int N_KEYS = 4,
  parameter int SUM_W  = 9 + $clog2(N_KEYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [7:0]       mac_data,
  output logic             mac_vld,
  input  logic             mac_rdy,
  output logic             mac_clr,
  input  logic [8:0]       exp_in,
  output logic [SUM_W-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             out_last,
  output logic             busy
);

  localparam int FW = $clog2(N_FEAT);
  localparam int KW = $clog2(N_KEYS);
  localparam int EW = KW + 1;

  localparam logic [FW-1:0] F_LAST = FW'(N_FEAT - 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_KEYS - 1);
  localparam logic [EW-1:0] E_LAST = EW'(N_KEYS);

  localparam logic [2:0] ST_LOAD_Q  = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_FETCH_K = 3'd2;
  localparam logic [2:0] ST_PAIR_A  = 3'd3;
  localparam logic [2:0] ST_PAIR_B1 = 3'd4;
  localparam logic [2:0] ST_PAIR_B2 = 3'd5;
  localparam logic [2:0] ST_CAPTURE = 3'd6;
  localparam logic [2:0] ST_EMIT    = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [FW-1:0]    f_cnt_q, f_cnt_d;
  logic [KW-1:0]    k_cnt_q, k_cnt_d;
  logic [EW-1:0]    e_idx_q, e_idx_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [7:0]       kreg_q, kreg_d;
  logic [7:0]       q_q [N_FEAT];
  logic [8:0]       exp_buf_q [N_KEYS];
  logic             q_we;
  logic             buf_we;

  always_comb begin
    state_d = state_q;
    f_cnt_d = f_cnt_q;
    k_cnt_d = k_cnt_q;
    e_idx_d = e_idx_q;
    sum_d   = sum_q;
    kreg_d  = kreg_q;
    q_we    = 1'b0;
    buf_we  = 1'b0;
    case (state_q)
      ST_LOAD_Q: begin
        if (in_vld) begin
          q_we = 1'b1;
          if (f_cnt_q == F_LAST) begin
            f_cnt_d = '0;
            state_d = ST_CLEAR;
          end else begin
            f_cnt_d = f_cnt_q + 1'b1;
          end
        end
      end
      ST_CLEAR: state_d = ST_FETCH_K;
      ST_FETCH_K: begin
        if (in_vld) begin
          kreg_d  = in_data;
          state_d = ST_PAIR_A;
        end
      end
      ST_PAIR_A: begin
        if (mac_rdy) state_d = ST_PAIR_B1;
      end
      // Beat B is held for B1 and B2 regardless of mac_rdy; the engine multiplies in B2.
      ST_PAIR_B1: state_d = ST_PAIR_B2;
      ST_PAIR_B2: begin
        if (f_cnt_q == F_LAST) begin
          f_cnt_d = '0;
          state_d = ST_CAPTURE;
        end else begin
          f_cnt_d = f_cnt_q + 1'b1;
          state_d = ST_FETCH_K;
        end
      end
      ST_CAPTURE: begin
        buf_we = 1'b1;
        sum_d  = sum_q + SUM_W'(exp_in);
        if (k_cnt_q == K_LAST) begin
          k_cnt_d = '0;
          state_d = ST_EMIT;
        end else begin
          k_cnt_d = k_cnt_q + 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_EMIT: begin
        if (out_rdy) begin
          if (e_idx_q == E_LAST) begin
            e_idx_d = '0;
            sum_d   = '0;
            state_d = ST_LOAD_Q;
          end else begin
            e_idx_d = e_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD_Q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LOAD_Q;
      f_cnt_q <= '0;
      k_cnt_q <= '0;
      e_idx_q <= '0;
      sum_q   <= '0;
      kreg_q  <= '0;
      for (int i = 0; i < N_FEAT; i++) q_q[i] <= '0;
      for (int i = 0; i < N_KEYS; i++) exp_buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      f_cnt_q <= f_cnt_d;
      k_cnt_q <= k_cnt_d;
      e_idx_q <= e_idx_d;
      sum_q   <= sum_d;
      kreg_q  <= kreg_d;
      if (q_we) q_q[f_cnt_q] <= in_data;
      if (buf_we) exp_buf_q[k_cnt_q] <= exp_in;
    end
  end

  // Outputs decode registered state only; rst_n forces them quiet while reset is held.
  assign in_rdy   = rst_n && (state_q == ST_LOAD_Q || state_q == ST_FETCH_K);
  assign mac_vld  = rst_n && (state_q == ST_PAIR_A || state_q == ST_PAIR_B1 ||
                              state_q == ST_PAIR_B2);
  assign mac_data = !mac_vld ? 8'h00 : ((state_q == ST_PAIR_A) ? q_q[f_cnt_q] : kreg_q);
  assign mac_clr  = rst_n && (state_q == ST_CLEAR);
  assign out_vld  = rst_n && (state_q == ST_EMIT);
  assign out_last = out_vld && (e_idx_q == E_LAST);
  assign out_data = !out_vld ? '0 :
                    (out_last ? sum_q : SUM_W'(exp_buf_q[e_idx_q[KW-1:0]]));
  assign busy     = rst_n && !(state_q == ST_LOAD_Q && f_cnt_q == '0);

endmodule

// File: tb/tb_attn_row_scheduler.sv
// Directed bench for attn_row_scheduler at default parameters (4 features, 4 keys).
module tb_attn_row_scheduler;

  localparam int SUM_W = 11;

  logic             clk;
  logic             rst_n;
  logic [7:0]       in_data;
  logic             in_vld;
  logic             in_rdy;
  logic [7:0]       mac_data;
  logic             mac_vld;
  logic             mac_rdy;
  logic             mac_clr;
  logic [8:0]       exp_in;
  logic [SUM_W-1:0] out_data;
  logic             out_vld;
  logic             out_rdy;
  logic             out_last;
  logic             busy;

  int tests_run;
  int tests_failed;

  logic [7:0] q_vec [4];
  logic [7:0] k_vec [16];
  logic [8:0] exp_tab [4];

  logic [7:0]       mac_log [$];
  logic [SUM_W-1:0] out_log [$];
  logic             last_log [$];
  int clr_cnt, cyc_cnt, stall_seen, stall_viol, hold_viol;
  bit row_done;

  attn_row_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .mac_data(mac_data), .mac_vld(mac_vld), .mac_rdy(mac_rdy), .mac_clr(mac_clr),
    .exp_in(exp_in),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_data(input logic [7:0] qb, input logic [7:0] kb);
    for (int i = 0; i < 4; i++) q_vec[i] = qb + 8'(i);
    for (int i = 0; i < 16; i++) k_vec[i] = kb + 8'(i);
  endtask

  // Drives one full row with inputs set at negedge, observes 1 ns later, logs handshakes.
  task automatic drive_row(input int stall_pair, input int stall_len, input bit out_toggle);
    int in_idx, a_cnt, b_left;
    bit hold_pend;
    logic [SUM_W-1:0] hold_data;
    logic hold_last;
    mac_log.delete(); out_log.delete(); last_log.delete();
    clr_cnt = 0; cyc_cnt = 0; stall_seen = 0; stall_viol = 0; hold_viol = 0;
    row_done = 1'b0; in_idx = 0; a_cnt = 0; b_left = 0; hold_pend = 1'b0;
    hold_data = '0; hold_last = 1'b0;
    while (!row_done && cyc_cnt < 300) begin
      @(negedge clk);
      in_vld  = (in_idx < 20);
      in_data = (in_idx < 4) ? q_vec[in_idx] : ((in_idx < 20) ? k_vec[in_idx-4] : 8'h00);
      mac_rdy = !(a_cnt == stall_pair && stall_seen < stall_len);
      out_rdy = out_toggle ? cyc_cnt[0] : 1'b1;
      exp_in  = (clr_cnt > 0) ? exp_tab[clr_cnt-1] : 9'h000;
      #1;
      cyc_cnt++;
      if (mac_vld) begin
        if (b_left > 0) begin
          mac_log.push_back(mac_data);
          b_left--;
        end else if (mac_rdy) begin
          mac_log.push_back(mac_data);
          b_left = 2;
          a_cnt++;
        end else begin
          stall_seen++;
          if (mac_data !== q_vec[a_cnt % 4] || in_rdy !== 1'b0) stall_viol++;
        end
      end
      if (mac_clr) clr_cnt++;
      if (in_vld && in_rdy) in_idx++;
      if (hold_pend && (!out_vld || out_data !== hold_data || out_last !== hold_last))
        hold_viol++;
      hold_pend = 1'b0;
      if (out_vld) begin
        if (out_rdy) begin
          out_log.push_back(out_data);
          last_log.push_back(out_last);
          $display("[TB] out beat data=%h last=%0b", out_data, out_last);
          if (out_last) row_done = 1'b1;
        end else begin
          hold_pend = 1'b1;
          hold_data = out_data;
          hold_last = out_last;
        end
      end
    end
    in_vld = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    logic [7:0] vals;
    vals = {in_rdy, mac_vld, mac_clr, out_vld, out_last, busy, |mac_data, |out_data};
    tests_run++;
    if (vals !== 8'h00) begin
      tests_failed++;
      $display("FAIL %s: output flags {in_rdy,mac_vld,mac_clr,out_vld,out_last,busy,mac_data!=0,out_data!=0} got %b expected 00000000",
               tag, vals);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in_data = 8'($urandom); in_vld = 1'($urandom); mac_rdy = 1'($urandom);
      out_rdy = 1'($urandom); exp_in = 9'($urandom);
      #1;
      check_outputs_zero("reset_outputs");
    end
    @(negedge clk);
    rst_n = 1'b1; in_vld = 1'b0; mac_rdy = 1'b1; out_rdy = 1'b1;
    #1;
    tests_run++;
    if (in_rdy !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: in_rdy=%b busy=%b expected in_rdy=1 busy=0", in_rdy, busy);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic check_row(input string tag, input logic [SUM_W-1:0] e0, input logic [SUM_W-1:0] e1,
                           input logic [SUM_W-1:0] e2, input logic [SUM_W-1:0] e3,
                           input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] exp_beats [5];
    exp_beats[0] = e0; exp_beats[1] = e1; exp_beats[2] = e2; exp_beats[3] = e3; exp_beats[4] = s;
    tests_run++;
    if (!row_done || out_log.size() != 5) begin
      tests_failed++;
      $display("FAIL %s_beats: done=%0b beats=%0d expected done=1 beats=5", tag, row_done, out_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (out_log[i] !== exp_beats[i] || last_log[i] !== (i == 4)) begin
          tests_failed++;
          $display("FAIL %s_beat%0d: data=%h last=%b expected data=%h last=%b", tag, i,
                   out_log[i], last_log[i], exp_beats[i], (i == 4));
        end
      end
    end
  endtask

  task automatic check_mac_order(input string tag);
    logic [7:0] want;
    tests_run++;
    if (mac_log.size() != 48) begin
      tests_failed++;
      $display("FAIL %s_mac_count: got %0d beats expected 48", tag, mac_log.size());
    end else begin
      for (int p = 0; p < 16; p++) begin
        for (int b = 0; b < 3; b++) begin
          want = (b == 0) ? q_vec[p % 4] : k_vec[p];
          tests_run++;
          if (mac_log[p*3+b] !== want) begin
            tests_failed++;
            $display("FAIL %s_mac_pair%0d_beat%0d: got %h expected %h", tag, p, b, mac_log[p*3+b], want);
          end
        end
      end
    end
  endtask

  task automatic test_operand_order;
    set_data(8'h01, 8'h10);
    for (int i = 0; i < 4; i++) exp_tab[i] = 9'h040;
    drive_row(-1, 0, 1'b0);
    check_mac_order("order");
    tests_run++;
    if (clr_cnt != 4) begin
      tests_failed++;
      $display("FAIL order_clr_pulses: got %0d expected 4", clr_cnt);
    end
    check_row("order", 11'h040, 11'h040, 11'h040, 11'h040, 11'h100);
    tests_run++;
    if (cyc_cnt != 81) begin
      tests_failed++;
      $display("FAIL order_latency: got %0d cycles expected 81", cyc_cnt);
    end
    $display("[TB] test_operand_order done");
  endtask

  task automatic test_mac_backpressure;
    set_data(8'h21, 8'h40);
    for (int i = 0; i < 4; i++) exp_tab[i] = 9'h040;
    drive_row(5, 5, 1'b0);
    tests_run++;
    if (stall_seen != 5 || stall_viol != 0) begin
      tests_failed++;
      $display("FAIL mac_stall: stall cycles=%0d violations=%0d expected 5 and 0", stall_seen, stall_viol);
    end
    check_mac_order("mac_bp");
    check_row("mac_bp", 11'h040, 11'h040, 11'h040, 11'h040, 11'h100);
    tests_run++;
    if (cyc_cnt != 86) begin
      tests_failed++;
      $display("FAIL mac_bp_latency: got %0d cycles expected 86", cyc_cnt);
    end
    $display("[TB] test_mac_backpressure done");
  endtask

  task automatic test_out_backpressure;
    set_data(8'h05, 8'h60);
    exp_tab[0] = 9'h001; exp_tab[1] = 9'h002; exp_tab[2] = 9'h003; exp_tab[3] = 9'h004;
    drive_row(-1, 0, 1'b1);
    check_row("out_bp", 11'h001, 11'h002, 11'h003, 11'h004, 11'h00A);
    tests_run++;
    if (hold_viol != 0) begin
      tests_failed++;
      $display("FAIL out_bp_hold: got %0d unstable stalled beats expected 0", hold_viol);
    end
    $display("[TB] test_out_backpressure done");
  endtask

  task automatic test_max_values;
    set_data(8'h7F, 8'h70);
    for (int i = 0; i < 4; i++) exp_tab[i] = 9'h1FF;
    drive_row(-1, 0, 1'b0);
    check_row("max", 11'h1FF, 11'h1FF, 11'h1FF, 11'h1FF, 11'h7FC);
    for (int i = 0; i < 4; i++) exp_tab[i] = 9'h040;
    drive_row(-1, 0, 1'b0);
    check_row("max_next_row", 11'h040, 11'h040, 11'h040, 11'h040, 11'h100);
    $display("[TB] test_max_values done");
  endtask

  task automatic test_reset_mid_row;
    int in_idx, clr, mv, cyc;
    bit hit;
    set_data(8'h01, 8'h10);
    in_idx = 0; clr = 0; mv = 0; cyc = 0; hit = 1'b0;
    while (!hit && cyc < 200) begin
      @(negedge clk);
      in_vld  = (in_idx < 20);
      in_data = (in_idx < 4) ? q_vec[in_idx] : ((in_idx < 20) ? k_vec[in_idx-4] : 8'h00);
      mac_rdy = 1'b1; out_rdy = 1'b1; exp_in = 9'h040;
      #1;
      cyc++;
      if (in_vld && in_rdy) in_idx++;
      if (mac_clr) clr++;
      if (clr == 3 && mac_vld) begin
        mv++;
        if (mv == 2) hit = 1'b1;
      end
    end
    tests_run++;
    if (!hit || mac_data !== 8'h18) begin
      tests_failed++;
      $display("FAIL midrst_reach_b1: reached=%0b mac_data=%h expected reached=1 mac_data=18", hit, mac_data);
    end
    rst_n = 1'b0;
    in_vld = 1'b0;
    @(negedge clk);
    #1;
    check_outputs_zero("midrst_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (in_rdy !== 1'b1 || busy !== 1'b0 || mac_vld !== 1'b0 || out_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_release: in_rdy=%b busy=%b mac_vld=%b out_vld=%b expected 1 0 0 0",
               in_rdy, busy, mac_vld, out_vld);
    end
    for (int i = 0; i < 4; i++) exp_tab[i] = 9'h040;
    drive_row(-1, 0, 1'b0);
    check_mac_order("midrst_fresh");
    check_row("midrst_fresh", 11'h040, 11'h040, 11'h040, 11'h040, 11'h100);
    $display("[TB] test_reset_mid_row done");
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0; in_data = 8'h00; in_vld = 1'b0; mac_rdy = 1'b0; out_rdy = 1'b0; exp_in = 9'h000;
    test_reset;
    test_operand_order;
    test_mac_backpressure;
    test_out_backpressure;
    test_max_values;
    test_reset_mid_row;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
